// File: rtl/id_ex_ctrl_if.sv
// ID/EX control-stage bus: decoder bundle and register fields in, registered EX bundle,
// stall, sticky illegal flag and event counters out.
interface id_ex_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_RegDst;
  logic             id_ALUSrc;
  logic             id_MemtoReg;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic             id_MemWrite;
  logic             id_Branch;
  logic [1:0]       id_ALUOp;
  logic             flush;
  logic             stall;
  logic             ex_valid;
  logic             ex_RegDst;
  logic             ex_ALUSrc;
  logic             ex_MemtoReg;
  logic             ex_RegWrite;
  logic             ex_MemRead;
  logic             ex_MemWrite;
  logic             ex_Branch;
  logic [1:0]       ex_ALUOp;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd,
           id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_ALUOp, flush,
    input  stall, ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp, ex_rs, ex_rt, ex_rd,
           illegal, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd,
           id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_ALUOp, flush,
    output stall, ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_ALUOp, ex_rs, ex_rt, ex_rd,
           illegal, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for the decoder control bundle with load-use hazard detection,
// bubble insertion on hazard/flush/illegal opcode, and saturating stall/flush counters.
module id_ex_ctrl_stage #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_ctrl_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Bundle layout: [8]RegDst [7]ALUSrc [6]MemtoReg [5]RegWrite [4]MemRead [3]MemWrite [2]Branch [1:0]ALUOp
  function automatic logic [8:0] f_clean9(input logic [8:0] v);
    for (int i = 0; i < 9; i++) f_clean9[i] = (v[i] === 1'b1) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [5:0] f_clean6(input logic [5:0] v);
    for (int i = 0; i < 6; i++) f_clean6[i] = (v[i] === 1'b1) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [4:0] f_clean5(input logic [4:0] v);
    for (int i = 0; i < 5; i++) f_clean5[i] = (v[i] === 1'b1) ? 1'b1 : 1'b0;
  endfunction

  logic             w_valid;
  logic             w_flush;
  logic [5:0]       w_op;
  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [8:0]       w_ctrl;
  logic [8:0]       w_ctrl_san;
  logic             w_supported;
  logic             w_uses_rt;
  logic             w_hz;
  logic             w_stall;
  logic             w_bubble;

  logic             r_valid;
  logic [8:0]       r_ctrl;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_rd;
  logic             r_illegal;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // X/Z on any ID input collapses to 0 so EX only ever sees defined values.
  assign w_valid = (bus.id_valid === 1'b1) ? 1'b1 : 1'b0;
  assign w_flush = (bus.flush === 1'b1) ? 1'b1 : 1'b0;
  assign w_op    = f_clean6(bus.id_opcode);
  assign w_rs    = f_clean5(bus.id_rs);
  assign w_rt    = f_clean5(bus.id_rt);
  assign w_rd    = f_clean5(bus.id_rd);
  assign w_ctrl  = f_clean9({bus.id_RegDst, bus.id_ALUSrc, bus.id_MemtoReg, bus.id_RegWrite,
                             bus.id_MemRead, bus.id_MemWrite, bus.id_Branch, bus.id_ALUOp});

  // Opcode classification: which opcodes are legal and which read rt.
  always_comb begin
    w_supported = 1'b0;
    w_uses_rt   = 1'b0;
    case (w_op)
      OP_RTYPE: begin w_supported = 1'b1; w_uses_rt = 1'b1; end
      OP_LW:    begin w_supported = 1'b1; w_uses_rt = 1'b0; end
      OP_SW:    begin w_supported = 1'b1; w_uses_rt = 1'b1; end
      OP_BEQ:   begin w_supported = 1'b1; w_uses_rt = 1'b1; end
      default:  begin w_supported = 1'b0; w_uses_rt = 1'b0; end
    endcase
  end

  // Hazard, stall and bubble decision plus RegWrite-dependent sanitising.
  always_comb begin
    w_ctrl_san = w_ctrl;
    if (w_ctrl[5] == 1'b0) begin
      w_ctrl_san[8] = 1'b0;
      w_ctrl_san[6] = 1'b0;
    end else begin
      w_ctrl_san = w_ctrl;
    end
    w_hz     = r_valid & r_ctrl[4] & (r_rt != 5'd0) & w_valid &
               ((r_rt == w_rs) | (w_uses_rt & (r_rt == w_rt)));
    w_stall  = w_hz & ~w_flush;
    w_bubble = w_flush | w_hz | ~w_valid | ~w_supported;
  end

  // EX-stage register: bubble or sanitised ID bundle; illegal is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= 9'd0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
    end else begin
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= 9'd0;
        r_rs    <= 5'd0;
        r_rt    <= 5'd0;
        r_rd    <= 5'd0;
      end else begin
        r_valid <= 1'b1;
        r_ctrl  <= w_ctrl_san;
        r_rs    <= w_rs;
        r_rt    <= w_rt;
        r_rd    <= w_rd;
      end
      if (w_valid && !w_supported) r_illegal <= 1'b1;
      else                         r_illegal <= r_illegal;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        r_stall_cnt <= r_stall_cnt;
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else
        r_flush_cnt <= r_flush_cnt;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.ex_valid    = r_valid;
  assign bus.ex_RegDst   = r_ctrl[8];
  assign bus.ex_ALUSrc   = r_ctrl[7];
  assign bus.ex_MemtoReg = r_ctrl[6];
  assign bus.ex_RegWrite = r_ctrl[5];
  assign bus.ex_MemRead  = r_ctrl[4];
  assign bus.ex_MemWrite = r_ctrl[3];
  assign bus.ex_Branch   = r_ctrl[2];
  assign bus.ex_ALUOp    = r_ctrl[1:0];
  assign bus.ex_rs       = r_rs;
  assign bus.ex_rt       = r_rt;
  assign bus.ex_rd       = r_rd;
  assign bus.illegal     = r_illegal;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed plus randomized bench for id_ex_ctrl_stage against a rule-level reference model.
module tb_id_ex_ctrl_stage;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_ctrl_if #(.CNT_W(CW)) bus();
  id_ex_ctrl_stage #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Reference model of the EX stage contents, expressed in spec terms.
  bit       m_valid;
  bit [8:0] m_ctrl;
  bit [4:0] m_rs, m_rt, m_rd;
  bit       m_ill;
  int       m_sc, m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = 9'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    m_ill = 1'b0; m_sc = 0; m_fc = 0;
  endtask

  function automatic bit is_sup(input bit [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
  endfunction

  function automatic bit model_hz(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt);
    bit reads_rt;
    reads_rt = is_sup(op) && (op != 6'h23);
    return m_valid && m_ctrl[4] && (m_rt != 5'd0) && v &&
           ((m_rt == rs) || (reads_rt && (m_rt == rt)));
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".ctrl"}, {23'd0, bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite,
                         bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch, bus.ex_ALUOp}, {23'd0, m_ctrl});
    chk({tag, ".valid"}, {31'd0, bus.ex_valid}, {31'd0, m_valid});
    chk({tag, ".rs"}, {27'd0, bus.ex_rs}, {27'd0, m_rs});
    chk({tag, ".rt"}, {27'd0, bus.ex_rt}, {27'd0, m_rt});
    chk({tag, ".rd"}, {27'd0, bus.ex_rd}, {27'd0, m_rd});
    chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, m_ill});
    chk({tag, ".stall_cnt"}, {28'd0, bus.stall_cnt}, m_sc);
    chk({tag, ".flush_cnt"}, {28'd0, bus.flush_cnt}, m_fc);
  endtask

  task automatic set_in(input bit v, input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [4:0] rd, input logic [8:0] c, input bit fl);
    bus.id_valid = v; bus.id_opcode = op; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    {bus.id_RegDst, bus.id_ALUSrc, bus.id_MemtoReg, bus.id_RegWrite,
     bus.id_MemRead, bus.id_MemWrite, bus.id_Branch, bus.id_ALUOp} = c;
    bus.flush = fl;
  endtask

  // One pipeline cycle: drive ID, check combinational stall, clock, update model, check EX.
  task automatic step(input string tag, input bit v, input bit [5:0] op, input bit [4:0] rs,
                      input bit [4:0] rt, input bit [4:0] rd, input logic [8:0] c, input bit fl);
    bit [8:0] c2;
    bit hz;
    set_in(v, op, rs, rt, rd, c, fl);
    #1;
    for (int i = 0; i < 9; i++) c2[i] = (c[i] === 1'b1);
    hz = model_hz(v, op, rs, rt);
    chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, hz && !fl});
    @(posedge clk);
    if (fl) m_fc = (m_fc < MAX) ? m_fc + 1 : MAX;
    if (hz && !fl) m_sc = (m_sc < MAX) ? m_sc + 1 : MAX;
    if (v && !is_sup(op)) m_ill = 1'b1;
    if (fl || hz || !v || !is_sup(op)) begin
      m_valid = 1'b0; m_ctrl = 9'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0;
    end else begin
      m_valid = 1'b1; m_ctrl = c2; m_rs = rs; m_rt = rt; m_rd = rd;
      if (!c2[5]) begin m_ctrl[8] = 1'b0; m_ctrl[6] = 1'b0; end
    end
    #1;
    check_outs(tag);
  endtask

  function automatic bit [5:0] rand_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 5)       return 6'h00;
    else if (r < 10) return 6'h23;
    else if (r < 15) return 6'h2B;
    else if (r < 19) return 6'h04;
    else             return 6'($urandom_range(0, 63));
  endfunction

  localparam logic [8:0] B_ADD = 9'b100100010;
  localparam logic [8:0] B_LW  = 9'b011110000;
  localparam logic [8:0] B_SWX = 9'bx1x001000;
  localparam logic [8:0] B_BEQ = 9'b000000101;

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 9'd0, 1'b0);
    model_reset();
    #2;
    check_outs("reset");
    chk("reset.stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    step("rtype", 1'b1, 6'h00, 5'd1, 5'd2, 5'd3, B_ADD, 1'b0);
    chk("rtype.RegDst", {31'd0, bus.ex_RegDst}, 32'd1);
    chk("rtype.ALUOp", {30'd0, bus.ex_ALUOp}, 32'd2);

    step("lw5", 1'b1, 6'h23, 5'd1, 5'd5, 5'd0, B_LW, 1'b0);
    step("add_hz", 1'b1, 6'h00, 5'd5, 5'd2, 5'd6, B_ADD, 1'b0);
    chk("add_hz.bubble", {31'd0, bus.ex_valid}, 32'd0);
    step("add_go", 1'b1, 6'h00, 5'd5, 5'd2, 5'd6, B_ADD, 1'b0);
    chk("add_go.valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("add_go.stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);

    step("swx", 1'b1, 6'h2B, 5'd3, 5'd4, 5'd0, B_SWX, 1'b0);
    chk("swx.MemWrite", {31'd0, bus.ex_MemWrite}, 32'd1);
    chk("swx.RegDst", {31'd0, bus.ex_RegDst}, 32'd0);

    step("lw7", 1'b1, 6'h23, 5'd2, 5'd7, 5'd0, B_LW, 1'b0);
    step("beq_fl", 1'b1, 6'h04, 5'd7, 5'd1, 5'd0, B_BEQ, 1'b1);
    chk("beq_fl.flush_cnt", {28'd0, bus.flush_cnt}, 32'd1);
    chk("beq_fl.stall_cnt", {28'd0, bus.stall_cnt}, 32'd1);

    step("lw_lw_rt", 1'b1, 6'h23, 5'd2, 5'd7, 5'd0, B_LW, 1'b0);
    step("lw_lw_rt2", 1'b1, 6'h23, 5'd3, 5'd7, 5'd0, B_LW, 1'b0);
    step("lw_lw_rs", 1'b1, 6'h23, 5'd7, 5'd8, 5'd0, B_LW, 1'b0);
    step("lw0", 1'b1, 6'h23, 5'd1, 5'd0, 5'd0, B_LW, 1'b0);
    step("r0", 1'b1, 6'h00, 5'd0, 5'd0, 5'd4, B_ADD, 1'b0);

    step("illegal", 1'b1, 6'b001000, 5'd1, 5'd2, 5'd3, B_ADD, 1'b0);
    chk("illegal.flag", {31'd0, bus.illegal}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      bit [5:0] op;
      case ($urandom_range(0, 3))
        0:       op = 6'h00;
        1:       op = 6'h23;
        2:       op = 6'h2B;
        default: op = 6'h04;
      endcase
      step("post_ill", 1'b1, op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 9'($urandom_range(0, 511)), 1'b0);
    end
    chk("post_ill.flag", {31'd0, bus.illegal}, 32'd1);

    for (int i = 0; i < 20; i++) step("flush_hold", 1'b1, 6'h00, 5'd1, 5'd2, 5'd3, B_ADD, 1'b1);
    chk("flush_sat", {28'd0, bus.flush_cnt}, 32'd15);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 99) < 85), rand_op(), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 9'($urandom_range(0, 511)),
           ($urandom_range(0, 99) < 10));
    end

    step("mid_lw", 1'b1, 6'h23, 5'd1, 5'd9, 5'd0, B_LW, 1'b0);
    set_in(1'b1, 6'h00, 5'd9, 5'd2, 5'd3, B_ADD, 1'b0);
    #1;
    chk("mid.stall_pre", {31'd0, bus.stall}, 32'd1);
    chk("mid.illegal_pre", {31'd0, bus.illegal}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid.stall_rst", {31'd0, bus.stall}, 32'd0);
    check_outs("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("post_rst", 1'b1, 6'h00, 5'd1, 5'd2, 5'd3, B_ADD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
